// File: rtl/commit_ctrl_pkg.sv
// Shared types and constants for the N-lane commit/exception controller.
package commit_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_IDLE  = 2'd2
  } state_t;

  localparam int unsigned EXCP_INT    = 0;
  localparam int unsigned EXCP_ADEF   = 1;
  localparam int unsigned EXCP_TLBR_F = 2;
  localparam int unsigned EXCP_PIF    = 3;
  localparam int unsigned EXCP_PPI_F  = 4;
  localparam int unsigned EXCP_SYS    = 5;
  localparam int unsigned EXCP_BRK    = 6;
  localparam int unsigned EXCP_INE    = 7;
  localparam int unsigned EXCP_IPE    = 8;
  localparam int unsigned EXCP_ALE    = 9;
  localparam int unsigned EXCP_ADEM   = 10;
  localparam int unsigned EXCP_TLBR_M = 11;
  localparam int unsigned EXCP_PIS    = 12;
  localparam int unsigned EXCP_PME    = 13;
  localparam int unsigned EXCP_PPI_M  = 14;
  localparam int unsigned EXCP_PIL    = 15;

  // Exception classes whose bad VA is the fetch PC or the memory address
  localparam logic [15:0] FETCH_EXCP_MASK = 16'h001E;
  localparam logic [15:0] MEM_EXCP_MASK   = 16'hFE00;

  typedef struct packed {
    logic        valid;
    logic        excp;
    logic        ertn;
    logic        idle;
    logic        refetch;
    logic [15:0] excp_num;
    logic [31:0] pc;
    logic [31:0] mem_addr;
  } lane_rec_t;

  function automatic logic is_fetch_excp(input int unsigned idx);
    return (idx < 16) && FETCH_EXCP_MASK[idx[3:0]];
  endfunction

  function automatic logic is_mem_excp(input int unsigned idx);
    return (idx < 16) && MEM_EXCP_MASK[idx[3:0]];
  endfunction

endpackage

// File: rtl/commit_prio_sel.sv
// Lowest-set-bit finder: reports whether any bit is set and the index of the lowest one.
module commit_prio_sel #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/commit_ctrl.sv
// N-lane commit/exception controller with flush-hold and IDLE-wait states.
// Optional performance counters are built when COMMIT_CTRL_PERF_EN is defined.
module commit_ctrl
  import commit_ctrl_pkg::*;
#(
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned NUM_STAGES   = 7,
  parameter int unsigned EXCP_W       = 16,
  parameter int unsigned FLUSH_HOLD   = 2,
  localparam int unsigned LANE_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1,
  localparam int unsigned EXCP_IDX_W  = (EXCP_W > 1) ? $clog2(EXCP_W) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_WIDTH-1:0]      lane_valid_i,
  input  logic [COMMIT_WIDTH-1:0]      lane_excp_i,
  input  logic [COMMIT_WIDTH*EXCP_W-1:0] lane_excp_num_i,
  input  logic [COMMIT_WIDTH*32-1:0]   lane_pc_i,
  input  logic [COMMIT_WIDTH*32-1:0]   lane_mem_addr_i,
  input  logic [COMMIT_WIDTH-1:0]      lane_ertn_i,
  input  logic [COMMIT_WIDTH-1:0]      lane_idle_i,
  input  logic [COMMIT_WIDTH-1:0]      lane_refetch_i,
  input  logic [NUM_STAGES-1:0]        stage_ready_i,
  input  logic                         intr_pending_i,
  output logic [COMMIT_WIDTH-1:0]      commit_mask_o,
  output logic [NUM_STAGES-1:0]        flush_o,
  output logic [NUM_STAGES-1:0]        advance_o,
  output logic                         excp_valid_o,
  output logic [LANE_W-1:0]            excp_lane_o,
  output logic [EXCP_IDX_W-1:0]        excp_idx_o,
  output logic [31:0]                  era_o,
  output logic [31:0]                  badv_o,
  output logic                         badv_we_o,
  output logic                         ertn_o,
  output logic                         redirect_o,
  output logic                         idle_o
`ifdef COMMIT_CTRL_PERF_EN
  ,
  output logic [63:0]                  perf_commit_cnt_o,
  output logic [31:0]                  perf_flush_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(FLUSH_HOLD + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               to_idle_q, to_idle_d;
  logic [31:0]        idle_pc_q, idle_pc_d;
  logic               prev_ready_q;

  logic               ready_all;
  logic               flush_evt;
  logic [COMMIT_WIDTH-1:0] term_vec;
  logic               term_found;
  logic [LANE_W-1:0]  term_idx;
  int unsigned        t_pos;
  logic               term_excp, term_ertn, term_idle;
  logic [31:0]        term_pc, term_mem;
  logic [EXCP_W-1:0]  term_excp_num;
  logic               excp_num_found;
  logic [EXCP_IDX_W-1:0] excp_sel_idx;

  logic [31:0]        pc_arr   [COMMIT_WIDTH];
  logic [31:0]        mem_arr  [COMMIT_WIDTH];
  logic [EXCP_W-1:0]  enum_arr [COMMIT_WIDTH];

  assign ready_all = &stage_ready_i;
  assign term_vec  = lane_valid_i & (lane_excp_i | lane_ertn_i | lane_idle_i | lane_refetch_i);

  always_comb begin
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      pc_arr[i]   = lane_pc_i[i*32 +: 32];
      mem_arr[i]  = lane_mem_addr_i[i*32 +: 32];
      enum_arr[i] = lane_excp_num_i[i*EXCP_W +: EXCP_W];
    end
  end

  commit_prio_sel #(.WIDTH(COMMIT_WIDTH), .IDX_W(LANE_W)) u_term_sel (
    .vec   (term_vec),
    .found (term_found),
    .idx   (term_idx)
  );

  assign term_excp     = lane_excp_i[term_idx];
  assign term_ertn     = lane_ertn_i[term_idx];
  assign term_idle     = lane_idle_i[term_idx];
  assign term_pc       = pc_arr[term_idx];
  assign term_mem      = mem_arr[term_idx];
  assign term_excp_num = enum_arr[term_idx];
  assign t_pos         = term_found ? 32'(term_idx) : COMMIT_WIDTH;

  commit_prio_sel #(.WIDTH(EXCP_W), .IDX_W(EXCP_IDX_W)) u_excp_sel (
    .vec   (term_excp_num),
    .found (excp_num_found),
    .idx   (excp_sel_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      cnt_q        <= '0;
      to_idle_q    <= 1'b0;
      idle_pc_q    <= '0;
      prev_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_idle_q    <= to_idle_d;
      idle_pc_q    <= idle_pc_d;
      prev_ready_q <= ready_all;
    end
  end

  // Next-state and same-cycle commit/flush/report outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    to_idle_d     = to_idle_q;
    idle_pc_d     = idle_pc_q;
    flush_evt     = 1'b0;
    commit_mask_o = '0;
    flush_o       = '0;
    advance_o     = {NUM_STAGES{ready_all}};
    excp_valid_o  = 1'b0;
    excp_lane_o   = '0;
    excp_idx_o    = '0;
    era_o         = '0;
    badv_o        = '0;
    badv_we_o     = 1'b0;
    ertn_o        = 1'b0;
    redirect_o    = 1'b0;
    idle_o        = 1'b0;

    case (state_q)
      S_RUN: begin
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
          commit_mask_o[i] = lane_valid_i[i] & ready_all &
                             ((i < t_pos) | ((i == t_pos) & ~lane_excp_i[i]));
        end
        if (ready_all && term_found) begin
          flush_o    = '1;
          redirect_o = 1'b1;
          flush_evt  = 1'b1;
          to_idle_d  = 1'b0;
          if (term_excp) begin
            excp_valid_o = 1'b1;
            excp_lane_o  = term_idx;
            excp_idx_o   = excp_sel_idx;
            era_o        = term_pc;
            if (excp_num_found && is_fetch_excp(32'(excp_sel_idx))) begin
              badv_o    = term_pc;
              badv_we_o = 1'b1;
            end else if (excp_num_found && is_mem_excp(32'(excp_sel_idx))) begin
              badv_o    = term_mem;
              badv_we_o = 1'b1;
            end
          end else if (term_ertn) begin
            ertn_o = 1'b1;
          end else if (term_idle) begin
            idle_pc_d = term_pc + 32'd4;
            to_idle_d = 1'b1;
          end else begin
            era_o = term_pc;
          end
          if (FLUSH_HOLD == 1) begin
            state_d   = to_idle_d ? S_IDLE : S_RUN;
            to_idle_d = 1'b0;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(FLUSH_HOLD - 1);
          end
        end else if (prev_ready_q && !ready_all) begin
          flush_o[0] = 1'b1;
        end
      end

      S_FLUSH: begin
        flush_o = '1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d   = to_idle_q ? S_IDLE : S_RUN;
          cnt_d     = '0;
          to_idle_d = 1'b0;
        end
      end

      S_IDLE: begin
        advance_o = '0;
        idle_o    = 1'b1;
        if (intr_pending_i) begin
          excp_valid_o = 1'b1;
          era_o        = idle_pc_q;
          redirect_o   = 1'b1;
          flush_o      = '1;
          flush_evt    = 1'b1;
          to_idle_d    = 1'b0;
          if (FLUSH_HOLD == 1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_FLUSH;
            cnt_d   = CNT_W'(FLUSH_HOLD - 1);
          end
        end
      end

      default: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
    endcase

    // Reset holds every output at its idle value, advance stays open
    if (rst) begin
      flush_evt     = 1'b0;
      commit_mask_o = '0;
      flush_o       = '0;
      advance_o     = '1;
      excp_valid_o  = 1'b0;
      excp_lane_o   = '0;
      excp_idx_o    = '0;
      era_o         = '0;
      badv_o        = '0;
      badv_we_o     = 1'b0;
      ertn_o        = 1'b0;
      redirect_o    = 1'b0;
      idle_o        = 1'b0;
    end
  end

`ifdef COMMIT_CTRL_PERF_EN
  logic [63:0] commit_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [LANE_W:0] commit_pop;

  always_comb begin
    commit_pop = '0;
    for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
      commit_pop = commit_pop + (LANE_W + 1)'(commit_mask_o[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_q + 64'(commit_pop);
      flush_cnt_q  <= flush_cnt_q + 32'(flush_evt);
    end
  end

  assign perf_commit_cnt_o = commit_cnt_q;
  assign perf_flush_cnt_o  = flush_cnt_q;
`endif

endmodule
